// File: rtl/dlx_pipe_if.sv
// dlx_pipe_if -- DLX instruction fetch stage.
//
// Owns the program counter, drives a req/ack instruction-memory port and
// produces the IF/ID pipeline register consumed by dlx_pipe_id.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   stall, dc_wait      hold the IF/ID register (both behave identically)
//   id_cond, id_npc     taken branch/jump from ID and its target
//   id_halt             ID decoded a halt
//   id_illegal_instr    ID decoded an illegal opcode
//   imem_req/adr        fetch request and word-aligned address (= pc)
//   imem_ack/rdata      fetch completion and fetched word
//   if_id_ir/npc        IF/ID instruction and next-PC
//   if_halted           sticky: fetch has stopped
//   if_illegal          sticky: the stop was caused by an illegal opcode
//
// States
//   FETCH  request outstanding at pc
//   HOLD   a word arrived while stalled; it waits in the fetch buffer
//   DRAIN  halted with a request outstanding; wait for its ack and drop it
//   HALT   fetch stopped until reset
module dlx_pipe_if #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        dc_wait,
  input  logic        id_cond,
  input  logic [31:0] id_npc,
  input  logic        id_halt,
  input  logic        id_illegal_instr,
  output logic        imem_req,
  output logic [31:0] imem_adr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_ir,
  output logic [31:0] if_id_npc,
  output logic        if_halted,
  output logic        if_illegal
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_d, npc_d;
  logic        halted_d, illegal_d;
  logic        pend_q, pend_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] buf_ir_p0, buf_npc_p0;
  logic        buf_ld;

  logic        adv;
  logic        take;
  logic        halt_ev;
  logic [31:0] id_tgt;
  logic [31:0] pc_inc;

  // ID controls only count when the pipe advances; halt outranks a branch.
  assign adv     = ~stall & ~dc_wait;
  assign halt_ev = adv & (id_halt | id_illegal_instr);
  assign take    = adv & id_cond & ~halt_ev;
  assign id_tgt  = id_npc & ~32'h0000_0003;
  assign pc_inc  = pc_q + 32'd4;

  assign imem_req = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_adr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = if_id_ir;
    npc_d      = if_id_npc;
    halted_d   = if_halted;
    illegal_d  = if_illegal;
    pend_d     = pend_q;
    redir_pc_d = redir_pc_q;
    buf_ld     = 1'b0;
    case (state_q)
      FETCH: begin
        if (halt_ev) begin
          ir_d      = NOP_INSTR;
          halted_d  = 1'b1;
          illegal_d = id_illegal_instr;
          pend_d    = 1'b0;
          state_d   = imem_ack ? HALT : DRAIN;
        end else if (imem_ack) begin
          if (pend_q || take) begin
            // Word belongs to the wrong path: drop it and jump.
            pc_d   = pend_q ? redir_pc_q : id_tgt;
            pend_d = 1'b0;
            if (adv) ir_d = NOP_INSTR;
          end else if (adv) begin
            ir_d  = imem_rdata;
            npc_d = pc_inc;
            pc_d  = pc_inc;
          end else begin
            // Memory finished while stalled: park the word.
            buf_ld  = 1'b1;
            pc_d    = pc_inc;
            state_d = HOLD;
          end
        end else if (take) begin
          // Request cannot be aborted; remember the target until it acks.
          pend_d     = 1'b1;
          redir_pc_d = id_tgt;
          ir_d       = NOP_INSTR;
        end else if (adv) begin
          ir_d = NOP_INSTR;
        end
      end
      HOLD: begin
        if (halt_ev) begin
          ir_d      = NOP_INSTR;
          halted_d  = 1'b1;
          illegal_d = id_illegal_instr;
          state_d   = HALT;
        end else if (take) begin
          pc_d    = id_tgt;
          ir_d    = NOP_INSTR;
          state_d = FETCH;
        end else if (adv) begin
          ir_d    = buf_ir_p0;
          npc_d   = buf_npc_p0;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (imem_ack) state_d = HALT;
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = FETCH;
    endcase
  end

  // Stage boundary: PC, IF/ID register and control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      if_id_ir   <= NOP_INSTR;
      if_id_npc  <= RESET_PC;
      if_halted  <= 1'b0;
      if_illegal <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_id_ir   <= ir_d;
      if_id_npc  <= npc_d;
      if_halted  <= halted_d;
      if_illegal <= illegal_d;
      pend_q     <= pend_d;
    end
  end

  // Stage boundary: fetch buffer and pending redirect target (data only).
  always_ff @(posedge clk) begin
    redir_pc_q <= redir_pc_d;
    if (buf_ld) begin
      buf_ir_p0  <= imem_rdata;
      buf_npc_p0 <= pc_inc;
    end
  end

endmodule

// File: tb/tb_dlx_pipe_if.sv
module tb_dlx_pipe_if;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] XK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        dc_wait = 1'b0;
  logic        id_cond = 1'b0;
  logic [31:0] id_npc = 32'h0;
  logic        id_halt = 1'b0;
  logic        id_illegal_instr = 1'b0;
  logic        imem_req;
  logic [31:0] imem_adr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_ir;
  logic [31:0] if_id_npc;
  logic        if_halted;
  logic        if_illegal;

  // Memory model: every word is its address xor a fixed key.
  assign imem_rdata = imem_adr ^ XK;

  dlx_pipe_if #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .dc_wait(dc_wait),
    .id_cond(id_cond), .id_npc(id_npc), .id_halt(id_halt),
    .id_illegal_instr(id_illegal_instr),
    .imem_req(imem_req), .imem_adr(imem_adr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_id_ir(if_id_ir), .if_id_npc(if_id_npc),
    .if_halted(if_halted), .if_illegal(if_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  st;      // [0] stall, [1] dc_wait
    logic        ack;
    logic        cond;
    logic [31:0] npc_in;
    logic        halt;
    logic        ill;
    logic [31:0] e_ir;
    logic [31:0] e_npc;
    logic        e_req;
    logic [31:0] e_adr;
    logic        chk_adr;
    logic        e_halted;
    logic        e_ill;
    int          idx;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic r, logic [1:0] st, logic ack, logic cond,
                              logic [31:0] npc_in, logic halt, logic ill,
                              logic [31:0] e_ir, logic [31:0] e_npc, logic e_req,
                              logic [31:0] e_adr, logic chk_adr, logic e_h, logic e_i);
    vec_t v;
    v.rst = r; v.st = st; v.ack = ack; v.cond = cond; v.npc_in = npc_in;
    v.halt = halt; v.ill = ill; v.e_ir = e_ir; v.e_npc = e_npc; v.e_req = e_req;
    v.e_adr = e_adr; v.chk_adr = chk_adr; v.e_halted = e_h; v.e_ill = e_i;
    v.idx = 0;
    return v;
  endfunction

  task automatic check32(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %08h expected %08h", name, idx, act, exp);
    end
  endtask

  // Monitor: after every active edge, compare the DUT against the oldest expectation.
  initial begin
    vec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check32("if_id_ir",   e.idx, if_id_ir,   e.e_ir);
        check32("if_id_npc",  e.idx, if_id_npc,  e.e_npc);
        check32("imem_req",   e.idx, {31'b0, imem_req},   {31'b0, e.e_req});
        check32("if_halted",  e.idx, {31'b0, if_halted},  {31'b0, e.e_halted});
        check32("if_illegal", e.idx, {31'b0, if_illegal}, {31'b0, e.e_ill});
        if (e.chk_adr) check32("imem_adr", e.idx, imem_adr, e.e_adr);
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Driver: apply each vector on the falling edge and post its expectation.
  initial begin
    // reset (ack during reset is ignored)
    vecs.push_back(mk(1,0,0,0,0,0,0, NOP,32'h0,1,32'h0,1,0,0));
    vecs.push_back(mk(1,0,1,0,0,0,0, NOP,32'h0,1,32'h0,1,0,0));
    // zero-wait streaming
    vecs.push_back(mk(0,0,1,0,0,0,0, XK^32'h0,32'h4,1,32'h4,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, XK^32'h4,32'h8,1,32'h8,1,0,0));
    // ack delayed 3 cycles at 0x8
    vecs.push_back(mk(0,0,0,0,0,0,0, NOP,32'h8,1,32'h8,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, NOP,32'h8,1,32'h8,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, NOP,32'h8,1,32'h8,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, XK^32'h8,32'hC,1,32'hC,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, XK^32'hC,32'h10,1,32'h10,1,0,0));
    // stall when 0x10 acks: word parked, IF/ID held, req drops
    vecs.push_back(mk(0,1,1,0,0,0,0, XK^32'hC,32'h10,0,32'h14,1,0,0));
    vecs.push_back(mk(0,2,0,0,0,0,0, XK^32'hC,32'h10,0,32'h14,1,0,0));
    vecs.push_back(mk(0,1,0,1,32'h500,0,0, XK^32'hC,32'h10,0,32'h14,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, XK^32'h10,32'h14,1,32'h14,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, XK^32'h14,32'h18,1,32'h18,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, XK^32'h18,32'h1C,1,32'h1C,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, XK^32'h1C,32'h20,1,32'h20,1,0,0));
    // redirect while 0x20 outstanding
    vecs.push_back(mk(0,0,0,1,32'h100,0,0, NOP,32'h20,1,32'h20,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, NOP,32'h20,1,32'h20,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, NOP,32'h20,1,32'h100,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, XK^32'h100,32'h104,1,32'h104,1,0,0));
    // zero-wait redirect, target low bits forced to 0
    vecs.push_back(mk(0,0,1,1,32'h202,0,0, NOP,32'h104,1,32'h200,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, XK^32'h200,32'h204,1,32'h204,1,0,0));
    // redirect out of HOLD
    vecs.push_back(mk(0,1,1,0,0,0,0, XK^32'h200,32'h204,0,32'h208,1,0,0));
    vecs.push_back(mk(0,0,0,1,32'h300,0,0, NOP,32'h204,1,32'h300,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, XK^32'h300,32'h304,1,32'h304,1,0,0));
    // PC wrap at top of address space
    vecs.push_back(mk(0,0,1,1,32'hFFFF_FFFC,0,0, NOP,32'h304,1,32'hFFFF_FFFC,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, 32'h5A5A_FFFC,32'h0,1,32'h0,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, XK^32'h0,32'h4,1,32'h4,1,0,0));
    // halt while stalled is ignored; illegal with req outstanding drains
    vecs.push_back(mk(0,1,0,0,0,1,0, XK^32'h0,32'h4,1,32'h4,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1, NOP,32'h4,1,32'h4,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, NOP,32'h4,1,32'h4,1,1,1));
    vecs.push_back(mk(0,0,1,0,0,0,0, NOP,32'h4,0,32'h0,0,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, NOP,32'h4,0,32'h0,0,1,1));
    vecs.push_back(mk(0,0,1,1,32'h40,0,0, NOP,32'h4,0,32'h0,0,1,1));
    // reset out of HALT, then reset during outstanding req at 0x40
    vecs.push_back(mk(1,0,0,0,0,0,0, NOP,32'h0,1,32'h0,1,0,0));
    vecs.push_back(mk(0,0,1,1,32'h40,0,0, NOP,32'h0,1,32'h40,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, NOP,32'h0,1,32'h40,1,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0, NOP,32'h0,1,32'h0,1,0,0));
    // plain halt with zero-wait ack
    vecs.push_back(mk(0,0,1,0,0,0,0, XK^32'h0,32'h4,1,32'h4,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,1,0, NOP,32'h4,0,32'h0,0,1,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, NOP,32'h4,0,32'h0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,0, NOP,32'h0,1,32'h0,1,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      v.idx = i;
      @(negedge clk);
      rst              = v.rst;
      stall            = v.st[0];
      dc_wait          = v.st[1];
      imem_ack         = v.ack;
      id_cond          = v.cond;
      id_npc           = v.npc_in;
      id_halt          = v.halt;
      id_illegal_instr = v.ill;
      sb.push_back(v);
    end
    @(negedge clk);
    imem_ack = 1'b0; id_cond = 1'b0; id_halt = 1'b0; id_illegal_instr = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
